// File: rtl/frame_pattern_gen_if.sv
// Sample stream from the frame pattern generator toward the I2S sender.
// The generator drives the master side. The sender (or the bench) drives the slave side.
interface frame_pattern_gen_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic [SAMPLE_WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_first;
    logic                    out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_first,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_first,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/frame_pattern_gen.sv
// Test-pattern frame generator for the I2S sender test path.
// A frame has three parts, in this order:
//   - HEADER_COUNT header words;
//   - a payload of ramp, PRBS or constant words, chosen by mode;
//   - one trailer word that carries the count of frames completed so far.
// Each word is sent left-justified in a SAMPLE_WIDTH sample over a valid/ready handshake.
module frame_pattern_gen #(
    parameter int                                  SAMPLE_WIDTH = 24,
    parameter int                                  WORD_WIDTH   = 16,
    parameter int                                  HEADER_COUNT = 5,
    parameter logic [HEADER_COUNT*WORD_WIDTH-1:0]  HEADER_INIT  = {16'h0B77, 16'hA1DD, 16'h4240, 16'h2F84, 16'h2B03},
    parameter int                                  FRAME_WORDS  = 87,
    parameter logic [WORD_WIDTH-1:0]               FILL_WORD    = 16'h5A5A,
    parameter logic [WORD_WIDTH-1:0]               PRBS_SEED    = 16'hACE1,
    parameter logic [WORD_WIDTH-1:0]               PRBS_TAPS    = 16'hB400
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          mode,
    frame_pattern_gen_if.master bus,
    output logic [31:0]         frame_count
);

    localparam int IDX_W = $clog2(FRAME_WORDS);
    localparam logic [IDX_W-1:0] PAY_FIRST = IDX_W'(HEADER_COUNT);
    localparam logic [IDX_W-1:0] PAY_LAST  = IDX_W'(FRAME_WORDS - 2);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_WORDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One Galois LFSR step.
    function automatic logic [WORD_WIDTH-1:0] prbs_step(input logic [WORD_WIDTH-1:0] r);
        return (r >> 1) ^ (r[0] ? PRBS_TAPS : {WORD_WIDTH{1'b0}});
    endfunction

    // Header word i. Word 0 sits in the MSBs of HEADER_INIT.
    function automatic logic [WORD_WIDTH-1:0] header_word(input logic [IDX_W-1:0] i);
        logic [WORD_WIDTH-1:0] w;
        w = {WORD_WIDTH{1'b0}};
        for (int k = 0; k < HEADER_COUNT; k++) begin
            w = (IDX_W'(k) == i) ? HEADER_INIT[(HEADER_COUNT-1-k)*WORD_WIDTH +: WORD_WIDTH] : w;
        end
        return w;
    endfunction

    // Frame word at index i, given the latched mode, the current PRBS value and the completed-frame count.
    function automatic logic [WORD_WIDTH-1:0] word_at(
        input logic [IDX_W-1:0]      i,
        input logic [1:0]            m,
        input logic [WORD_WIDTH-1:0] prbs,
        input logic [31:0]           fc
    );
        logic [WORD_WIDTH-1:0] w;
        if (i < PAY_FIRST) begin
            w = header_word(i);
        end else if (i == LAST_IDX) begin
            w = WORD_WIDTH'(fc);
        end else begin
            case (m)
                2'd1:    w = prbs;
                2'd2:    w = FILL_WORD;
                default: w = WORD_WIDTH'(i);
            endcase
        end
        return w;
    endfunction

    // Place the word in the sample MSBs and zero-fill the low bits.
    function automatic logic [SAMPLE_WIDTH-1:0] to_sample(input logic [WORD_WIDTH-1:0] w);
        logic [SAMPLE_WIDTH-1:0] s;
        s = {SAMPLE_WIDTH{1'b0}};
        s[SAMPLE_WIDTH-1 -: WORD_WIDTH] = w;
        return s;
    endfunction

    state_t                  state_r, state_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic [WORD_WIDTH-1:0]   prbs_r, prbs_s;
    logic [1:0]              mode_r, mode_s;
    logic [SAMPLE_WIDTH-1:0] data_r, data_s;
    logic                    valid_r, valid_s;
    logic                    first_r, first_s;
    logic                    last_r, last_s;
    logic [31:0]             fc_r, fc_s;
    logic                    accept_s;
    logic                    is_payload_s;

    assign accept_s     = valid_r & bus.out_ready;
    assign is_payload_s = (idx_r >= PAY_FIRST) && (idx_r <= PAY_LAST);

    // Next-state, next-word and frame-sequencing decisions.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        prbs_s  = prbs_r;
        mode_s  = mode_r;
        data_s  = data_r;
        valid_s = valid_r;
        first_s = first_r;
        last_s  = last_r;
        fc_s    = fc_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_RUN;
                    idx_s   = {IDX_W{1'b0}};
                    mode_s  = mode;
                    prbs_s  = PRBS_SEED;
                    data_s  = to_sample(header_word({IDX_W{1'b0}}));
                    valid_s = 1'b1;
                    first_s = 1'b1;
                    last_s  = 1'b0;
                end else begin
                    valid_s = 1'b0;
                    first_s = 1'b0;
                    last_s  = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    if (idx_r == LAST_IDX) begin
                        fc_s = fc_r + 32'd1;
                        if (enable) begin
                            // Back-to-back frame: word 0 loads on the same edge that accepts the trailer.
                            idx_s   = {IDX_W{1'b0}};
                            mode_s  = mode;
                            prbs_s  = PRBS_SEED;
                            data_s  = to_sample(header_word({IDX_W{1'b0}}));
                            valid_s = 1'b1;
                            first_s = 1'b1;
                            last_s  = 1'b0;
                        end else begin
                            state_s = ST_IDLE;
                            valid_s = 1'b0;
                            first_s = 1'b0;
                            last_s  = 1'b0;
                        end
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                        // The LFSR advances only when a payload word is consumed.
                        if (is_payload_s) begin
                            prbs_s = prbs_step(prbs_r);
                        end else begin
                            prbs_s = prbs_r;
                        end
                        data_s  = to_sample(word_at(idx_s, mode_r, prbs_s, fc_r));
                        first_s = 1'b0;
                        last_s  = (idx_s == LAST_IDX);
                    end
                end else begin
                    // Stalled or nothing offered: hold the presented word unchanged.
                    valid_s = valid_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                first_s = 1'b0;
                last_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            prbs_r  <= PRBS_SEED;
            mode_r  <= 2'd0;
            data_r  <= {SAMPLE_WIDTH{1'b0}};
            valid_r <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
            fc_r    <= 32'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            prbs_r  <= prbs_s;
            mode_r  <= mode_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            first_r <= first_s;
            last_r  <= last_s;
            fc_r    <= fc_s;
        end
    end

    assign bus.out_data  = data_r;
    assign bus.out_valid = valid_r;
    assign bus.out_first = first_r;
    assign bus.out_last  = last_r;
    assign frame_count   = fc_r;

endmodule

// File: tb/tb_frame_pattern_gen.sv
// Bench for frame_pattern_gen.
// The reference model describes the expected stream as a sequence of frames.
// Each word is computed from the frame index, the latched mode and the completed-frame count.
// The directed phase follows the test plan. A randomized phase then checks the DUT against the model.
module tb_frame_pattern_gen;

    localparam int FW = 87;
    localparam int HC = 5;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic        ready;
    logic [31:0] frame_count;

    frame_pattern_gen_if #(.SAMPLE_WIDTH(24)) bus ();
    assign bus.out_ready = ready;

    frame_pattern_gen dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .bus         (bus),
        .frame_count (frame_count)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    bit          m_active = 1'b0;
    int          m_idx = 0;
    int          m_mode = 0;
    logic [31:0] m_fc = 32'd0;
    logic [23:0] cap [FW];
    logic [23:0] hdr_plan [HC];

    // Count one comparison and report it if the values differ.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [15:0] hdr_word(input int i);
        case (i)
            0:       return 16'h0B77;
            1:       return 16'hA1DD;
            2:       return 16'h4240;
            3:       return 16'h2F84;
            default: return 16'h2B03;
        endcase
    endfunction

    // PRBS value after n steps from the seed.
    function automatic logic [15:0] prbs_at(input int n);
        logic [15:0] r;
        r = 16'hACE1;
        for (int k = 0; k < n; k++) r = {1'b0, r[15:1]} ^ (r[0] ? 16'hB400 : 16'h0000);
        return r;
    endfunction

    function automatic logic [23:0] exp_sample(input int md, input int i, input logic [31:0] fc);
        logic [15:0] w;
        if (i < HC)           w = hdr_word(i);
        else if (i == FW - 1) w = fc[15:0];
        else if (md == 1)     w = prbs_at(i - HC);
        else if (md == 2)     w = 16'h5A5A;
        else                  w = 16'(i);
        return {w, 8'h00};
    endfunction

    // Drive one cycle of inputs, step the frame model at the edge, then check on the falling edge.
    task automatic cycle(input logic r, input logic e, input logic [1:0] md, input logic rdy);
        rst = r; enable = e; mode = md; ready = rdy;
        @(posedge clk);
        if (r) begin
            m_active = 1'b0; m_idx = 0; m_fc = 32'd0;
        end else if (!m_active) begin
            if (e) begin m_active = 1'b1; m_idx = 0; m_mode = int'(md); end
        end else if (rdy) begin
            if (m_idx == FW - 1) begin
                m_fc = m_fc + 32'd1;
                if (e) begin m_idx = 0; m_mode = int'(md); end
                else m_active = 1'b0;
            end else begin
                m_idx++;
            end
        end
        @(negedge clk);
        check_eq("valid", 32'(bus.out_valid), 32'(m_active));
        check_eq("frame_count", frame_count, m_fc);
        if (r) check_eq("rst_data", 32'(bus.out_data), 32'd0);
        if (m_active) begin
            check_eq("data", 32'(bus.out_data), 32'(exp_sample(m_mode, m_idx, m_fc)));
            check_eq("first", 32'(bus.out_first), 32'(m_idx == 0));
            check_eq("last", 32'(bus.out_last), 32'(m_idx == FW - 1));
            cap[m_idx] = bus.out_data;
        end
    endtask

    // Run with out_ready=1 until the model shows the given word index.
    task automatic run_to(input int target, input logic e, input logic [1:0] md);
        int guard;
        guard = 0;
        while (!(m_active && m_idx == target) && guard < 400) begin
            cycle(1'b0, e, md, 1'b1);
            guard++;
        end
        check_eq("reach_word", 32'(m_active && m_idx == target), 32'd1);
    endtask

    // Directed test-plan sequence, then randomized traffic.
    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'd0; ready = 1'b1;
        hdr_plan = '{24'h0B7700, 24'hA1DD00, 24'h424000, 24'h2F8400, 24'h2B0300};
        for (int i = 0; i < FW; i++) cap[i] = 24'h0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 2'd0, 1'b1);
        cycle(1'b1, 1'b0, 2'd0, 1'b1);
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);

        // Frame 1: ramp.
        cycle(1'b0, 1'b1, 2'd0, 1'b1);
        check_eq("lat_valid", 32'(bus.out_valid), 32'd1);
        check_eq("lat_first", 32'(bus.out_first), 32'd1);
        run_to(FW - 1, 1'b1, 2'd0);
        for (int i = 0; i < HC; i++) check_eq("f1_header", 32'(cap[i]), 32'(hdr_plan[i]));
        check_eq("f1_w5", 32'(cap[5]), 32'h000500);
        check_eq("f1_w85", 32'(cap[85]), 32'h005500);
        check_eq("f1_trailer", 32'(bus.out_data), 32'h000000);
        check_eq("f1_last", 32'(bus.out_last), 32'd1);

        // Frame 2: mode=1 is driven mid-frame and must be ignored.
        run_to(0, 1'b1, 2'd0);
        check_eq("f1_count", frame_count, 32'd1);
        run_to(FW - 1, 1'b1, 2'd1);
        check_eq("f2_trailer", 32'(bus.out_data), 32'h000100);

        // Frame 3: PRBS, with a 3-cycle stall at word 6.
        run_to(6, 1'b1, 2'd1);
        check_eq("f2_count", frame_count, 32'd2);
        check_eq("prbs_w5", 32'(cap[5]), 32'hACE100);
        check_eq("prbs_w6", 32'(bus.out_data), 32'hE27000);
        for (int s = 0; s < 3; s++) begin
            cycle(1'b0, 1'b1, 2'd2, 1'b0);
            check_eq("stall_hold", 32'(bus.out_data), 32'hE27000);
        end
        run_to(7, 1'b1, 2'd2);
        check_eq("prbs_w7", 32'(bus.out_data), 32'h713800);

        // Frame 4: constant fill. mode switches to ramp at word 20 and must not affect this frame.
        run_to(0, 1'b1, 2'd2);
        run_to(20, 1'b1, 2'd2);
        run_to(FW - 1, 1'b1, 2'd0);
        for (int i = HC; i < FW - 1; i++) check_eq("fill", 32'(cap[i]), 32'h5A5A00);

        // Frame 5: ramp. enable drops at word 40 and the frame still completes.
        run_to(40, 1'b1, 2'd0);
        check_eq("f5_w5", 32'(cap[5]), 32'h000500);
        check_eq("f5_w40", 32'(bus.out_data), 32'h002800);
        run_to(FW - 1, 1'b0, 2'd0);
        cycle(1'b0, 1'b0, 2'd0, 1'b1);
        check_eq("idle_valid", 32'(bus.out_valid), 32'd0);
        cycle(1'b0, 1'b0, 2'd0, 1'b1);
        check_eq("idle_valid2", 32'(bus.out_valid), 32'd0);
        cycle(1'b0, 1'b1, 2'd0, 1'b1);
        check_eq("restart_valid", 32'(bus.out_valid), 32'd1);
        check_eq("restart_data", 32'(bus.out_data), 32'h0B7700);
        check_eq("restart_first", 32'(bus.out_first), 32'd1);

        // Reset in the middle of a frame.
        run_to(30, 1'b1, 2'd0);
        cycle(1'b1, 1'b1, 2'd0, 1'b1);
        check_eq("midrst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_data", 32'(bus.out_data), 32'd0);
        check_eq("midrst_count", frame_count, 32'd0);
        cycle(1'b0, 1'b1, 2'd0, 1'b1);
        check_eq("postrst_data", 32'(bus.out_data), 32'h0B7700);
        check_eq("postrst_first", 32'(bus.out_first), 32'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            cycle(($urandom % 300) == 0, ($urandom % 8) != 0,
                  2'($urandom % 4), ($urandom % 4) != 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Bound on total simulation time.
    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
